// File: rtl/multi_timer.sv
// +--------------------------------------------------------------------------+
// | multi_timer: 2**CH_BITS bus-mapped down-counting timers with interrupts;  |
// | optional chaining via TIMER_CASCADE_EN.                  Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_timer #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      timer_cs,
  input  logic                      timer_wr,
  input  logic                      timer_rd,
  input  logic [CH_BITS+1:0]        timer_addr,
  input  logic [WIDTH-1:0]          timer_datain,
  output logic [WIDTH-1:0]          timer_value,
  output logic                      timer_INT,
  output logic [(2**CH_BITS)-1:0]   timer_irq_vec,
  output logic [(2**CH_BITS)-1:0]   timer_pulse
);

  localparam int CHANNELS = 2**CH_BITS;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic               wr_en;
  logic               rd_en;
  logic [CH_BITS-1:0] sel_ch;
  logic [1:0]         sel_reg;
  logic [WIDTH-1:0]   rd_word [CHANNELS];
  logic [WIDTH-1:0]   value_q, value_d;
`ifdef TIMER_CASCADE_EN
  logic [CHANNELS-1:0] expire_all;
`endif

  assign wr_en   = timer_cs & timer_wr;
  assign rd_en   = timer_cs & timer_rd & ~timer_wr;
  assign sel_ch  = timer_addr[CH_BITS+1:2];
  assign sel_reg = timer_addr[1:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] reload_q, reload_d, count_q, count_d, rdata;
    logic [7:0]       presc_q, presc_d, pcnt_q, pcnt_d;
    logic             run_q, run_d, auto_q, auto_d, irq_en_q, irq_en_d;
    logic             pend_q, pend_d, pulse_q, pulse_d;
    logic             ch_sel, presc_hit, use_casc, casc_in, tick, expire;
`ifdef TIMER_CASCADE_EN
    logic             casc_q, casc_d;
    if (i == 0) begin : g_base
      assign use_casc = 1'b0;
      assign casc_in  = 1'b0;
    end else begin : g_link
      assign use_casc = casc_q;
      assign casc_in  = expire_all[i-1];
    end
    assign expire_all[i] = expire;
`else
    assign use_casc = 1'b0;
    assign casc_in  = 1'b0;
`endif

    assign ch_sel    = (sel_ch == CH_BITS'(i));
    assign presc_hit = (pcnt_q == presc_q);
    assign tick      = run_q & (use_casc ? casc_in : presc_hit);
    assign expire    = tick & (count_q == '0);

    always_comb begin
      reload_d = reload_q;
      count_d  = count_q;
      presc_d  = presc_q;
      pcnt_d   = pcnt_q;
      run_d    = run_q;
      auto_d   = auto_q;
      irq_en_d = irq_en_q;
      pend_d   = pend_q;
      pulse_d  = pulse_q;
`ifdef TIMER_CASCADE_EN
      casc_d   = casc_q;
`endif
      if (run_q) begin
        pcnt_d = (use_casc || presc_hit) ? 8'd0 : pcnt_q + 8'd1;
        if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            pend_d  = 1'b1;
            pulse_d = ~pulse_q;
            if (auto_q) count_d = reload_q;
            else        run_d   = 1'b0;
          end
        end
      end
      // Bus writes are applied last so they override the counting path.
      if (wr_en && ch_sel) begin
        case (sel_reg)
          REG_RELOAD: reload_d = timer_datain;
          REG_CTRL: begin
            run_d    = timer_datain[0];
            auto_d   = timer_datain[1];
            irq_en_d = timer_datain[2];
`ifdef TIMER_CASCADE_EN
            casc_d   = timer_datain[3];
`endif
            presc_d  = timer_datain[15:8];
            if (timer_datain[0] && !run_q) begin
              count_d = reload_q;
              pcnt_d  = 8'd0;
            end
          end
          REG_COUNT: count_d = timer_datain;
          default: if (timer_datain[0] && !expire) pend_d = 1'b0;
        endcase
      end
    end

    always_comb begin
      rdata = '0;
      case (sel_reg)
        REG_RELOAD: rdata = reload_q;
        REG_CTRL: begin
          rdata[0]    = run_q;
          rdata[1]    = auto_q;
          rdata[2]    = irq_en_q;
`ifdef TIMER_CASCADE_EN
          rdata[3]    = casc_q;
`endif
          rdata[15:8] = presc_q;
        end
        REG_COUNT:  rdata = count_q;
        REG_STATUS: rdata[1:0] = {run_q, pend_q};
        default:    rdata = '0;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        reload_q <= '0;
        count_q  <= '0;
        presc_q  <= '0;
        pcnt_q   <= '0;
        run_q    <= 1'b0;
        auto_q   <= 1'b0;
        irq_en_q <= 1'b0;
        pend_q   <= 1'b0;
        pulse_q  <= 1'b0;
`ifdef TIMER_CASCADE_EN
        casc_q   <= 1'b0;
`endif
      end else begin
        reload_q <= reload_d;
        count_q  <= count_d;
        presc_q  <= presc_d;
        pcnt_q   <= pcnt_d;
        run_q    <= run_d;
        auto_q   <= auto_d;
        irq_en_q <= irq_en_d;
        pend_q   <= pend_d;
        pulse_q  <= pulse_d;
`ifdef TIMER_CASCADE_EN
        casc_q   <= casc_d;
`endif
      end
    end

    assign rd_word[i]       = rdata;
    assign timer_irq_vec[i] = pend_q & irq_en_q;
    assign timer_pulse[i]   = pulse_q;
  end

  always_comb begin
    value_d = value_q;
    if (rd_en) value_d = rd_word[sel_ch];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign timer_value = value_q;
  assign timer_INT   = |timer_irq_vec;

endmodule

`default_nettype wire

// File: tb/tb_multi_timer.sv
// +--------------------------------------------------------------------------+
// | tb_multi_timer: directed self-checking bench for multi_timer.            |
// |                                                          Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multi_timer;

  localparam int WIDTH   = 16;
  localparam int CH_BITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        timer_cs = 1'b0;
  logic        timer_wr = 1'b0;
  logic        timer_rd = 1'b0;
  logic [3:0]  timer_addr = '0;
  logic [15:0] timer_datain = '0;
  logic [15:0] timer_value;
  logic        timer_INT;
  logic [3:0]  timer_irq_vec;
  logic [3:0]  timer_pulse;

  int n_cmp = 0;
  int n_err = 0;

  multi_timer #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .timer_cs      (timer_cs),
    .timer_wr      (timer_wr),
    .timer_rd      (timer_rd),
    .timer_addr    (timer_addr),
    .timer_datain  (timer_datain),
    .timer_value   (timer_value),
    .timer_INT     (timer_INT),
    .timer_irq_vec (timer_irq_vec),
    .timer_pulse   (timer_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle; the strobes are sampled at the next rising edge.
  task automatic bus(input logic wr, input logic rd, input logic [3:0] a, input logic [15:0] d);
    timer_cs = 1'b1; timer_wr = wr; timer_rd = rd; timer_addr = a; timer_datain = d;
    @(posedge clk); #1;
    timer_cs = 1'b0; timer_wr = 1'b0; timer_rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    bus(1'b0, 1'b1, a, 16'h0);
    v = timer_value;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] v;
  logic        exp_p;

  initial begin
    #3;
    check_val("rst_value", timer_value, 16'h0);
    check_val("rst_int", timer_INT, 1'b0);
    check_val("rst_irqvec", timer_irq_vec, 4'h0);
    check_val("rst_pulse", timer_pulse, 4'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // One-shot on ch0: RELOAD=3, PRESC=0 -> pending after 4 edges.
    wr_reg(4'd0, 16'd3);
    wr_reg(4'd1, 16'h0005);
    cycles(3);
    check_val("os_int_early", timer_INT, 1'b0);
    cycles(1);
    check_val("os_int", timer_INT, 1'b1);
    check_val("os_irqvec", timer_irq_vec, 4'b0001);
    check_val("os_pulse", timer_pulse[0], 1'b1);
    rd_reg(4'd3, v);
    check_val("os_status", v, 16'h0001);
    cycles(10);
    check_val("os_no_reexp", timer_pulse[0], 1'b1);
    rd_reg(4'd2, v);
    check_val("os_count", v, 16'h0000);
    wr_reg(4'd3, 16'h0001);
    check_val("os_clr_int", timer_INT, 1'b0);

    // Auto-reload ch2: RELOAD=1, PRESC=2 -> toggle every 6 cycles.
    wr_reg(4'd8, 16'd1);
    wr_reg(4'd9, 16'h0203);
    exp_p = 1'b0;
    for (int p = 0; p < 5; p++) begin
      cycles(5);
      check_val("ar_hold", timer_pulse[2], exp_p);
      cycles(1);
      exp_p = ~exp_p;
      check_val("ar_toggle", timer_pulse[2], exp_p);
      check_val("ar_irqvec", timer_irq_vec, 4'h0);
    end
    wr_reg(4'd9, 16'h0000);

    // Clear race on ch1: RELOAD=0 auto-reload expires on every cycle.
    wr_reg(4'd4, 16'd0);
    wr_reg(4'd5, 16'h0007);
    wr_reg(4'd7, 16'h0001);
    check_val("race_int", timer_INT, 1'b1);
    rd_reg(4'd7, v);
    check_val("race_status", v, 16'h0003);
    wr_reg(4'd5, 16'h0004);
    rd_reg(4'd7, v);
    check_val("stop_status", v, 16'h0001);
    wr_reg(4'd7, 16'h0001);
    check_val("stop_clr_int", timer_INT, 1'b0);

    // Bus priority on ch3: simultaneous wr/rd performs only the write.
    wr_reg(4'd12, 16'hBEEF);
    rd_reg(4'd12, v);
    check_val("bp_reload", v, 16'hBEEF);
    bus(1'b1, 1'b1, 4'd14, 16'h1234);
    check_val("bp_value_held", timer_value, 16'hBEEF);
    rd_reg(4'd14, v);
    check_val("bp_count", v, 16'h1234);

    // CTRL readback masks unused bits; bit3 only exists with cascading.
    wr_reg(4'd13, 16'hABF8);
    rd_reg(4'd13, v);
`ifdef TIMER_CASCADE_EN
    check_val("ctrl_rb", v, 16'hAB08);
`else
    check_val("ctrl_rb", v, 16'hAB00);
`endif
    wr_reg(4'd13, 16'h0000);

`ifdef TIMER_CASCADE_EN
    // ch1 (RELOAD=1) counts ch0 (RELOAD=3) expiries -> period 8.
    wr_reg(4'd4, 16'd1);
    wr_reg(4'd5, 16'h000B);
    wr_reg(4'd0, 16'd3);
    exp_p = timer_pulse[1];
    wr_reg(4'd1, 16'h0003);
    cycles(7);
    check_val("cas_hold", timer_pulse[1], exp_p);
    cycles(1);
    exp_p = ~exp_p;
    check_val("cas_tog1", timer_pulse[1], exp_p);
    cycles(7);
    check_val("cas_hold2", timer_pulse[1], exp_p);
    cycles(1);
    exp_p = ~exp_p;
    check_val("cas_tog2", timer_pulse[1], exp_p);
    wr_reg(4'd5, 16'h0000);
    wr_reg(4'd1, 16'h0000);
`endif

    // Asynchronous reset in the middle of a count.
    wr_reg(4'd0, 16'd5);
    wr_reg(4'd1, 16'h0007);
    wr_reg(4'd4, 16'd0);
    wr_reg(4'd5, 16'h0007);
    rd_reg(4'd0, v);
    check_val("pre_rst_int", timer_INT, 1'b1);
    check_val("pre_rst_value", timer_value, 16'd5);
    #3 rst = 1'b0;
    #1;
    check_val("mid_rst_value", timer_value, 16'h0);
    check_val("mid_rst_int", timer_INT, 1'b0);
    check_val("mid_rst_irqvec", timer_irq_vec, 4'h0);
    check_val("mid_rst_pulse", timer_pulse, 4'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rd_reg(4'd2, v);
    check_val("post_rst_count", v, 16'h0);
    rd_reg(4'd1, v);
    check_val("post_rst_ctrl", v, 16'h0);
    cycles(3);
    check_val("post_rst_int", timer_INT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
